// File: rtl/fir_accum_if.sv
// Sample-stream, coefficient-ROM and result signals between the low-band
// queue, coefficient ROM, FIR accumulator and band mixer.
interface fir_accum_if #(
  parameter int ADDR_W = 10
);
  logic              seq_in;
  logic [15:0]       smpl_in;
  logic [ADDR_W-1:0] coeff_addr;
  logic [15:0]       coeff_data;
  logic [15:0]       smpl_out;
  logic              smpl_vld;
  logic              tap_err;

  modport slave (
    input  seq_in, smpl_in, coeff_data,
    output coeff_addr, smpl_out, smpl_vld, tap_err
  );

  modport master (
    output seq_in, smpl_in, coeff_data,
    input  coeff_addr, smpl_out, smpl_vld, tap_err
  );
endinterface

// File: rtl/fir_accum.sv
// One FIR evaluation per sequencing burst: tap x Q1.15 coefficient products
// are accumulated and a saturated 16-bit result is emitted 4 cycles after the last tap.
module fir_accum #(
  parameter int NUM_TAPS = 1021,
  parameter int ADDR_W   = 10,
  parameter int ACC_W    = 42
) (
  input  logic         clk,
  input  logic         rst,
  fir_accum_if.slave   bus
);
  localparam int CNT_W = $clog2(NUM_TAPS + 1);
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] MIN_V = -ACC_W'(32768);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                   r_state;
  logic [CNT_W-1:0]         r_tap_cnt;
  logic                     r_ovr;
  logic signed [15:0]       r_d_smpl;
  logic                     r_d_vld;
  logic                     r_d_first;
  logic signed [31:0]       r_prod;
  logic                     r_p_vld;
  logic                     r_p_first;
  logic                     r_p_end;
  logic                     r_p_err;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_a_end;
  logic                     r_a_err;
  logic [ADDR_W-1:0]        r_coeff_addr;
  logic [15:0]              r_smpl_out;
  logic                     r_smpl_vld;
  logic                     r_tap_err;

  logic                     w_start;
  logic                     w_accept;
  logic                     w_end;
  logic                     w_err;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_shift;
  logic [15:0]              w_sat;

  // Any seq_in rise outside RUN is tap 0, including one arriving during DRAIN.
  assign w_start    = bus.seq_in && (r_state != RUN);
  assign w_accept   = bus.seq_in && (w_start || (r_tap_cnt < CNT_W'(NUM_TAPS)));
  assign w_end      = !bus.seq_in && (r_state == RUN);
  assign w_err      = (r_tap_cnt != CNT_W'(NUM_TAPS)) || r_ovr;
  assign w_prod_ext = {{(ACC_W-32){r_prod[31]}}, r_prod};
  assign w_shift    = r_acc >>> 15;

  always_comb begin
    w_sat = w_shift[15:0];
    if (w_shift > MAX_V)
      w_sat = 16'h7FFF;
    else if (w_shift < MIN_V)
      w_sat = 16'h8000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_tap_cnt    <= '0;
      r_ovr        <= 1'b0;
      r_d_smpl     <= '0;
      r_d_vld      <= 1'b0;
      r_d_first    <= 1'b0;
      r_prod       <= '0;
      r_p_vld      <= 1'b0;
      r_p_first    <= 1'b0;
      r_p_end      <= 1'b0;
      r_p_err      <= 1'b0;
      r_acc        <= '0;
      r_a_end      <= 1'b0;
      r_a_err      <= 1'b0;
      r_coeff_addr <= '0;
      r_smpl_out   <= '0;
      r_smpl_vld   <= 1'b0;
      r_tap_err    <= 1'b0;
    end else begin
      r_d_vld   <= w_accept;
      r_d_first <= w_start;
      if (w_accept)
        r_d_smpl <= $signed(bus.smpl_in);

      if (w_start) begin
        r_state      <= RUN;
        r_coeff_addr <= '0;
        r_tap_cnt    <= CNT_W'(1);
        r_ovr        <= 1'b0;
      end else if (bus.seq_in) begin
        if (w_accept) begin
          r_coeff_addr <= ADDR_W'(r_tap_cnt);
          r_tap_cnt    <= r_tap_cnt + CNT_W'(1);
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_state == RUN) begin
        r_state <= DRAIN;
      end else if ((r_state == DRAIN) && r_a_end) begin
        r_state <= IDLE;
      end

      // The end marker is raised the cycle after the last tap, so it lines up
      // with that tap's product and then with its accumulator update.
      r_p_vld   <= r_d_vld;
      r_p_first <= r_d_first;
      r_prod    <= r_d_smpl * $signed(bus.coeff_data);
      r_p_end   <= w_end;
      r_p_err   <= w_err;

      if (r_p_vld)
        r_acc <= r_p_first ? w_prod_ext : (r_acc + w_prod_ext);
      r_a_end <= r_p_end;
      r_a_err <= r_p_err;

      r_smpl_vld <= r_a_end;
      if (r_a_end) begin
        r_smpl_out <= w_sat;
        r_tap_err  <= r_a_err;
      end
    end
  end

  assign bus.coeff_addr = r_coeff_addr;
  assign bus.smpl_out   = r_smpl_out;
  assign bus.smpl_vld   = r_smpl_vld;
  assign bus.tap_err    = r_tap_err;
endmodule

// File: tb/tb_fir_accum.sv
// Scoreboard bench for fir_accum: directed bursts push expected results,
// a negedge monitor pops and checks value, tap_err and latency on each smpl_vld.
module tb_fir_accum;
  localparam int NT = 1021;

  typedef struct {
    logic [15:0] v;
    logic        e;
    int          t;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_accum_if #(.ADDR_W(10)) bus ();

  fir_accum #(.NUM_TAPS(NT), .ADDR_W(10), .ACC_W(42)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] rom [0:1023];
  logic [15:0] smp [0:1099];
  exp_t        q [$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  assign bus.coeff_data = rom[bus.coeff_addr];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Monitor: every result pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.smpl_vld) begin
      if (q.size() == 0) begin
        chk("unexpected_vld", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        $display("result: smpl_out=0x%04h tap_err=%0b cycle=%0d (want 0x%04h err=%0b cycle=%0d)",
                 bus.smpl_out, bus.tap_err, cyc, e.v, e.e, e.t);
        chk("smpl_out", int'(bus.smpl_out), int'(e.v));
        chk("tap_err", int'(bus.tap_err), int'(e.e));
        chk("latency", cyc, e.t);
      end
    end
  end

  task automatic fill(input logic [15:0] s, input logic [15:0] c);
    for (int i = 0; i < 1100; i++) smp[i] = s;
    for (int i = 0; i < 1024; i++) rom[i] = c;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic run_burst(input int n, input logic [15:0] ev, input logic ee);
    int addr_bad;
    addr_bad = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.seq_in  = 1'b1;
      bus.smpl_in = smp[i];
      if (i == n - 1) q.push_back('{v: ev, e: ee, t: cyc + 4});
      @(negedge clk);
      if (i > 0 && int'(bus.coeff_addr) != mn(i - 1, NT - 1)) addr_bad++;
    end
    @(posedge clk);
    #1;
    bus.seq_in  = 1'b0;
    bus.smpl_in = 16'h0000;
    @(negedge clk);
    if (int'(bus.coeff_addr) != mn(n - 1, NT - 1)) addr_bad++;
    $display("burst: taps=%0d expect 0x%04h err=%0b addr_errors=%0d", n, ev, ee, addr_bad);
    chk("coeff_addr_seq", addr_bad, 0);
  endtask

  initial begin
    rst         = 1'b1;
    bus.seq_in  = 1'b0;
    bus.smpl_in = 16'h0000;
    fill(16'h0000, 16'h0001);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_smpl_out", int'(bus.smpl_out), 0);
    chk("reset_smpl_vld", int'(bus.smpl_vld), 0);
    chk("reset_coeff_addr", int'(bus.coeff_addr), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(3);

    // DC: 1021 * 0x4000 * 1 = 16,728,064 >>> 15 = 510
    fill(16'h4000, 16'h0001);
    run_burst(NT, 16'h01FE, 1'b0);
    idle(8);

    // Impulse: 0x7FFF * 0x4000 = 536,854,528 >>> 15 = 16383
    fill(16'h0000, 16'h0000);
    for (int i = 0; i < 1024; i++) rom[i] = 16'($urandom);
    rom[5] = 16'h4000;
    smp[5] = 16'h7FFF;
    run_burst(NT, 16'h3FFF, 1'b0);
    idle(8);

    fill(16'h7FFF, 16'h7FFF);
    run_burst(NT, 16'h7FFF, 1'b0);
    idle(8);

    fill(16'h8000, 16'h7FFF);
    run_burst(NT, 16'h8000, 1'b0);
    idle(8);

    // Short: 10 * 0x0100 * 0x7FFF = 83,883,520 >>> 15 = 2559
    fill(16'h0100, 16'h7FFF);
    run_burst(10, 16'h09FF, 1'b1);
    idle(8);

    // Single tap: 0x7FFF * 0x4000 >>> 15 = 16383
    fill(16'h7FFF, 16'h4000);
    run_burst(1, 16'h3FFF, 1'b1);
    idle(8);

    // Overrun: only the first 1021 taps count
    fill(16'h4000, 16'h0001);
    run_burst(NT + 4, 16'h01FE, 1'b1);
    idle(8);

    // Back-to-back, one low cycle between: B = 3 * 0x0100 * 0x7FFF >>> 15 = 767
    fill(16'h0100, 16'h7FFF);
    run_burst(10, 16'h09FF, 1'b1);
    run_burst(3, 16'h02FF, 1'b1);
    idle(20);
    chk("idle_hold", int'(bus.smpl_out), 16'h02FF);

    // Reset mid-burst: abandoned burst must produce nothing
    fill(16'h4000, 16'h0001);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      bus.seq_in  = 1'b1;
      bus.smpl_in = smp[i];
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus.seq_in  = 1'b0;
    bus.smpl_in = 16'h0000;
    @(negedge clk);
    chk("midrst_smpl_out", int'(bus.smpl_out), 0);
    chk("midrst_smpl_vld", int'(bus.smpl_vld), 0);
    chk("midrst_coeff_addr", int'(bus.coeff_addr), 0);
    idle(10);
    run_burst(NT, 16'h01FE, 1'b0);

    begin
      int waited;
      waited = 0;
      while (q.size() != 0 && waited < 50) begin
        @(posedge clk);
        waited++;
      end
      chk("pending_results", q.size(), 0);
    end
    idle(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
